time_digit_sequencer: RTL and testbench

//  Downstream of the DS1302 read controller. Watches the BCD hour and minute it publishes.
//  On a qualified change, snapshots HH:MM and emits it one digit at a time.

---
 rtl/time_digit_sequencer.sv | 156 +++++++++++++++
 tb/tb_time_digit_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_digit_sequencer.sv
// Qualifies BCD HH:MM changes published by the RTC reader and streams the digits over valid/ready.
// Optional: define TIME_SEP_EN for a 5-slot HH:MM frame carrying a colon token (4'hA) at slot 2.
module time_digit_sequencer #(
  parameter int MIN_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] read_hour,
  input  logic [7:0] read_minute,
  input  logic       force_redraw,
  input  logic       digit_ready,
  output logic       digit_valid,
  output logic [3:0] digit_value,
  output logic [2:0] digit_pos,
  output logic       busy,
  output logic       frame_done,
  output logic       bcd_err
);

`ifdef TIME_SEP_EN
  localparam logic [2:0] LAST_POS = 3'd4;
`else
  localparam logic [2:0] LAST_POS = 3'd3;
`endif
  localparam int CNT_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUAL  = 3'd1,
    S_CHECK = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [13:0]      r_last, w_last_nxt;
  logic             r_pend, w_pend_nxt;
  logic [12:0]      r_cand, r_snap;
  logic [12:0]      w_cur;
  logic             w_cand_ld, w_snap_ld;
  logic             w_unused;

  // Packed time: {hour[5:0], minute[6:0]}; the RTC mode/flag bits are ignored.
  assign w_cur    = {read_hour[5:0], read_minute[6:0]};
  assign w_unused = ^{read_hour[7:6], read_minute[7]};

  function automatic logic bcd_legal(input logic [12:0] t);
    return (t[10:7] <= 4'd9) && (t[12:7] <= 6'h23) && (t[6:4] <= 3'd5) && (t[3:0] <= 4'd9);
  endfunction

  function automatic logic [3:0] slot_digit(input logic [12:0] t, input logic [2:0] pos);
    logic [3:0] d;
    case (pos)
      3'd0:    d = {2'b00, t[12:11]};
      3'd1:    d = t[10:7];
`ifdef TIME_SEP_EN
      3'd2:    d = 4'hA;
      3'd3:    d = {1'b0, t[6:4]};
`else
      3'd2:    d = {1'b0, t[6:4]};
`endif
      default: d = t[3:0];
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= 14'h3FFF;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Candidate and frame snapshot are pure data; their load enables come from the FSM.
  always_ff @(posedge clk) begin
    if (w_cand_ld) r_cand <= w_cur;
    if (w_snap_ld) r_snap <= r_cand;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_pend_nxt  = r_pend | force_redraw;
    w_cand_ld   = 1'b0;
    w_snap_ld   = 1'b0;
    digit_valid = 1'b0;
    digit_value = 4'd0;
    digit_pos   = 3'd0;
    frame_done  = 1'b0;
    bcd_err     = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (({1'b0, w_cur} != r_last) || force_redraw || r_pend) begin
          w_state_nxt = S_QUAL;
          w_cand_ld   = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_pend_nxt  = 1'b0;
        end
      end
      S_QUAL: begin
        if (w_cur != r_cand) begin
          w_cand_ld = 1'b1;
          w_cnt_nxt = CNT_W'(1);
        end else if (r_cnt == HOLD_MAX) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        // Record even an illegal value so a stuck bad reading does not re-fire every cycle.
        w_last_nxt = {1'b0, r_cand};
        if (bcd_legal(r_cand)) begin
          w_snap_ld   = 1'b1;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_EMIT;
        end else begin
          bcd_err     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EMIT: begin
        digit_valid = 1'b1;
        digit_pos   = r_idx;
        digit_value = slot_digit(r_snap, r_idx);
        if (digit_ready) begin
          if (r_idx == LAST_POS) w_state_nxt = S_DONE;
          else                   w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_time_digit_sequencer.sv
// Randomized self-checking bench for time_digit_sequencer against a frame-level reference model.
module tb_time_digit_sequencer;
  localparam int MIN_HOLD = 4;
`ifdef TIME_SEP_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] read_hour = 8'h00;
  logic [7:0] read_minute = 8'h00;
  logic       force_redraw = 1'b0;
  logic       digit_ready = 1'b0;
  logic       digit_valid;
  logic [3:0] digit_value;
  logic [2:0] digit_pos;
  logic       busy;
  logic       frame_done;
  logic       bcd_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_bcd = 0;
  int          n_valid = 0;
  int          q_acc[$];
  int          exp_q[$];
  logic [13:0] model_last = 14'h3FFF;
  int          rdy_mode = 0;
  int          sc = 0;
  bit          prev_stall = 1'b0;
  logic [6:0]  prev_d = '0;

  always #5 clk = ~clk;

  time_digit_sequencer #(.MIN_HOLD(MIN_HOLD)) dut (
    .clk(clk), .rst(rst), .read_hour(read_hour), .read_minute(read_minute),
    .force_redraw(force_redraw), .digit_ready(digit_ready), .digit_valid(digit_valid),
    .digit_value(digit_value), .digit_pos(digit_pos), .busy(busy),
    .frame_done(frame_done), .bcd_err(bcd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: legality and digit order straight from decimal/BCD arithmetic.
  function automatic bit is_legal(input logic [12:0] t);
    int hr, mn;
    hr = int'(t[12:7]);
    mn = int'(t[6:0]);
    return (hr % 16 <= 9) && ((hr / 16) * 10 + hr % 16 <= 23) && (mn / 16 <= 5) && (mn % 16 <= 9);
  endfunction

  task automatic mk_frame(input logic [12:0] t);
    int hr, mn;
    int d[$];
    hr = int'(t[12:7]);
    mn = int'(t[6:0]);
    d.push_back(hr / 16);
    d.push_back(hr % 16);
`ifdef TIME_SEP_EN
    d.push_back(10);
`endif
    d.push_back(mn / 16);
    d.push_back(mn % 16);
    foreach (d[i]) exp_q.push_back(i * 16 + d[i]);
  endtask

  // Observer: accepted digits, pulse counts, and stall-hold stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(digit_valid), 32'd1);
        chk("hold_digit", 32'({digit_pos, digit_value}), 32'(prev_d));
      end
      prev_stall = digit_valid && !digit_ready;
      prev_d = {digit_pos, digit_value};
      if (digit_valid) n_valid++;
      if (digit_valid && digit_ready) q_acc.push_back(int'({digit_pos, digit_value}));
      if (frame_done) n_done++;
      if (bcd_err) n_bcd++;
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = five stall cycles per digit.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: digit_ready = 1'b1;
      1: digit_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (digit_valid) begin
          if (sc == 5) begin
            digit_ready = 1'b1;
            sc = 0;
          end else begin
            digit_ready = 1'b0;
            sc++;
          end
        end else begin
          digit_ready = 1'b0;
          sc = 0;
        end
      end
    endcase
  end

  task automatic compare_frames(input string tag, input int d_done, input int d_bcd,
                                input int e_done, input int e_bcd);
    chk({tag, ":ndig"}, 32'(q_acc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_acc.size(); i++)
      chk({tag, ":digit"}, 32'(q_acc[i]), 32'(exp_q[i]));
    chk({tag, ":frame_done"}, 32'(d_done), 32'(e_done));
    chk({tag, ":bcd_err"}, 32'(d_bcd), 32'(e_bcd));
    chk({tag, ":idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_case(input logic [7:0] h, input logic [7:0] m, input bit frc, input string tag);
    logic [12:0] cur;
    bit trig, legal, got, fin;
    int lat, b_done, b_bcd;
    cur = {h[5:0], m[6:0]};
    trig = frc || ({1'b0, cur} != model_last);
    legal = is_legal(cur);
    exp_q.delete();
    q_acc.delete();
    b_done = n_done;
    b_bcd = n_bcd;
    if (trig) begin
      model_last = {1'b0, cur};
      if (legal) mk_frame(cur);
    end
    @(posedge clk); #1;
    read_hour = h;
    read_minute = m;
    force_redraw = frc;
    rst = 1'b0;
    @(posedge clk); #1;
    force_redraw = 1'b0;
    if (trig && legal) begin
      lat = 1;
      @(negedge clk);
      got = digit_valid;
      while (!got && lat < 64) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        got = digit_valid;
      end
      chk({tag, ":latency"}, got ? 32'(lat) : 32'd0, 32'(MIN_HOLD + 2));
    end
    if (trig) begin
      fin = 1'b0;
      for (int k = 0; k < 400 && !fin; k++) begin
        @(negedge clk); #1;
        if (n_done != b_done || n_bcd != b_bcd) fin = 1'b1;
      end
      chk({tag, ":finish"}, 32'(fin), 32'd1);
      repeat (4) @(negedge clk);
    end else begin
      repeat (12) @(negedge clk);
    end
    #1;
    compare_frames(tag, n_done - b_done, n_bcd - b_bcd,
                   (trig && legal) ? 1 : 0, (trig && !legal) ? 1 : 0);
  endtask

  initial begin
    int b_done, b_val, sel, hv, mv;
    bit got;
    logic [7:0] h, m;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:digit_valid", 32'(digit_valid), 0);
    chk("rst:digit_value", 32'(digit_value), 0);
    chk("rst:digit_pos", 32'(digit_pos), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:frame_done", 32'(frame_done), 0);
    chk("rst:bcd_err", 32'(bcd_err), 0);

    rdy_mode = 0;
    do_case(8'h18, 8'h11, 1'b0, "first_1811");
    do_case(8'h18, 8'h11, 1'b0, "no_redraw");

    rdy_mode = 2;
    do_case(8'h18, 8'h12, 1'b0, "slow_1812");

    rdy_mode = 0;
    b_val = n_valid;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      read_minute = (i % 2 == 0) ? 8'h13 : 8'h12;
      @(posedge clk);
    end
    @(negedge clk);
    chk("toggle:quiet", 32'(n_valid - b_val), 0);
    chk("toggle:busy", 32'(busy), 1);
    do_case(8'h18, 8'h13, 1'b0, "settle_1813");

    do_case(8'h2A, 8'h13, 1'b0, "bad_hour");
    do_case(8'h10, 8'h60, 1'b0, "bad_minute");
    do_case(8'h10, 8'h60, 1'b0, "bad_no_retry");
    do_case(8'h24, 8'h00, 1'b0, "bad_24h");
    do_case(8'h23, 8'h59, 1'b0, "max_2359");
    do_case(8'hD8, 8'h93, 1'b0, "masked_1813");

    // Force during digit 1 of a forced frame: two identical frames.
    rdy_mode = 2;
    exp_q.delete();
    q_acc.delete();
    b_done = n_done;
    mk_frame({6'h18, 7'h13});
    mk_frame({6'h18, 7'h13});
    @(posedge clk); #1 force_redraw = 1'b1;
    @(posedge clk); #1 force_redraw = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (digit_valid && digit_pos == 3'd1) got = 1'b1;
    end
    chk("force:pos1_seen", 32'(got), 1);
    @(posedge clk); #1 force_redraw = 1'b1;
    @(posedge clk); #1 force_redraw = 1'b0;
    for (int k = 0; k < 800 && (n_done - b_done) < 2; k++) begin
      @(negedge clk); #1;
    end
    repeat (4) @(negedge clk);
    #1;
    compare_frames("force", n_done - b_done, 0, 2, 0);

    // Reset in the middle of a frame, then a full redraw of the same time.
    @(posedge clk); #1;
    read_hour = 8'h09;
    read_minute = 8'h45;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (digit_valid && digit_pos == 3'd2) got = 1'b1;
    end
    chk("midrst:pos2_seen", 32'(got), 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst:digit_valid", 32'(digit_valid), 0);
    chk("midrst:digit_value", 32'(digit_value), 0);
    chk("midrst:digit_pos", 32'(digit_pos), 0);
    chk("midrst:busy", 32'(busy), 0);
    chk("midrst:frame_done", 32'(frame_done), 0);
    chk("midrst:bcd_err", 32'(bcd_err), 0);
    model_last = 14'h3FFF;
    repeat (2) @(posedge clk);
    do_case(8'h09, 8'h45, 1'b0, "after_rst");

    for (int it = 0; it < 40; it++) begin
      rdy_mode = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        do_case(read_hour, read_minute, 1'b1, "rnd_force");
      end else if (sel < 4) begin
        h = 8'($urandom_range(0, 255));
        m = 8'($urandom_range(0, 255));
        do_case(h, m, 1'($urandom_range(0, 1)), "rnd_any");
      end else begin
        hv = $urandom_range(0, 23);
        mv = $urandom_range(0, 59);
        h = 8'((hv / 10) * 16 + hv % 10) | 8'($urandom_range(0, 3) << 6);
        m = 8'((mv / 10) * 16 + mv % 10) | 8'($urandom_range(0, 1) << 7);
        do_case(h, m, 1'b0, "rnd_legal");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
